// File: rtl/slow_window_pkg.sv
// slow_window shared definitions.
// FSM encoding, timeout width and default timebase divider.
package slow_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int TO_W         = 4;
    localparam int TICK_DIV_DEF = 16;

endpackage

// File: rtl/slow_window_tick.sv
// slow_tick: free-running hold timebase prescaler.
// Emits a one-cycle tick when the count reaches TICK_DIV-1.
module slow_tick #(
    parameter int TICK_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/slow_window.sv
// slow_window: decides when the accelerator must run at
// motherboard speed, with a programmable post-access hold.
module slow_window
    import slow_window_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic            CLK,
    input  logic            nPOR,
    input  logic            BACT,
    input  logic            IACKCS,
    input  logic            VIACS,
    input  logic            IWMCS,
    input  logic            SCCCS,
    input  logic            SCSICS,
    input  logic            SndCS,
    input  logic            SlowIACK,
    input  logic            SlowVIA,
    input  logic            SlowIWM,
    input  logic            SlowSCC,
    input  logic            SlowSCSI,
    input  logic            SlowSnd,
    input  logic            SlowClockGate,
    input  logic [TO_W-1:0] SlowTimeout,
    output logic            SlowReq,
    output logic            SlowHold,
    output logic            ClockGate
);

    state_t          r_state;
    state_t          w_next;
    logic            r_bactr;
    logic            r_gatel;
    logic [TO_W-1:0] r_tl;
    logic [TO_W-1:0] r_hcnt;
    logic            w_tick;
    logic            w_sel;
    logic            w_hit;

    slow_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (CLK),
        .i_rst_n (nPOR),
        .o_tick  (w_tick)
    );

    assign w_sel = |{IACKCS & SlowIACK, VIACS & SlowVIA,
                     IWMCS & SlowIWM, SCCCS & SlowSCC,
                     SCSICS & SlowSCSI, SndCS & SlowSnd};

    // Selects only count on the first cycle of a bus access.
    assign w_hit = BACT & ~r_bactr & w_sel;

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            r_bactr <= 1'b0;
        end else begin
            r_bactr <= BACT;
        end
    end

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hit) w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!BACT) begin
                    w_next = (r_tl == '0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_hit) begin
                    w_next = ST_ACTIVE;
                end else if (w_tick && r_hcnt == TO_W'(1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A reload from a new hit takes priority over a same-cycle tick.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            r_tl    <= '0;
            r_gatel <= 1'b0;
            r_hcnt  <= '0;
        end else begin
            if (w_hit && r_state != ST_ACTIVE) begin
                r_tl    <= SlowTimeout;
                r_gatel <= SlowClockGate;
            end
            if (r_state == ST_ACTIVE && !BACT) begin
                r_hcnt <= r_tl;
            end else if (r_state == ST_HOLD && !w_hit && w_tick) begin
                r_hcnt <= r_hcnt - TO_W'(1);
            end
        end
    end

    always_comb begin
        SlowReq   = (r_state != ST_IDLE);
        SlowHold  = (r_state == ST_HOLD);
        ClockGate = (r_state != ST_IDLE) & r_gatel;
    end

endmodule

// File: doc/slow_window.md
# slow_window

Consumer side of the slow-settings register. Watches each bus cycle's peripheral selects and applies the current Slow* enables and SlowTimeout to decide whether the accelerator must drop to motherboard-speed clocking. When the accelerator must slow down, it asserts a registered slow request and holds it for a programmable number of timebase ticks after the access ends. Sits between the address decoder and the clock-switch logic, and reads the settings register's outputs directly.

## Interface

Parameters:
- TICK_DIV, 16: CLK cycles per hold-timebase tick; must be ≥ 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nPOR  in  1  reset; asynchronous, active-low.
- BACT  in  1  bus cycle active; select inputs are valid whenever BACT=1.
- IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS  in  1 each  decoded peripheral selects for the current cycle.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-peripheral slow enables from the settings register.
- SlowClockGate  in  1  settings flag enabling clock gating during a slow window.
- SlowTimeout  in  4  hold length in ticks after a slow access ends.
- SlowReq  out  1  slow clocking required (state ≠ IDLE).
- SlowHold  out  1  post-access hold in progress (state = HOLD).
- ClockGate  out  1  gate request = SlowReq AND the SlowClockGate value latched at window start.

## Operation

- BACTr is BACT registered. Cycle start is BACT=1 AND BACTr=0.
- Hit is true at cycle start when any (xxxCS AND Slowxxx) pair is 1. Selects are sampled only at cycle start.
- FSM states: IDLE, ACTIVE, HOLD.
  - IDLE → ACTIVE on hit. Latch GateL ← SlowClockGate.
  - ACTIVE → stays while BACT=1. On BACT=0: if the latched timeout TL = 0, go to IDLE; otherwise go to HOLD with Cnt ← TL.
  - TL is captured from SlowTimeout at the hit. Later changes to SlowTimeout do not affect the current window.
  - HOLD: Cnt decrements on each tick. On a tick with Cnt = 1, go to IDLE.
  - HOLD → ACTIVE on a hit. TL and GateL are recaptured, and any tick in that cycle is ignored because the reload wins.
  - Non-slow cycles, including a cycle start with no hit, do not alter HOLD or Cnt.
- Prescaler: free-running counter 0..TICK_DIV-1 from reset. Tick is high in the cycle the counter equals TICK_DIV-1. The prescaler is not resynchronised by window start.
- Settings changes while in ACTIVE never drop SlowReq early.
- Reset mid-window: outputs go low immediately (asynchronous). The state returns to IDLE and the prescaler restarts at 0.

## Timing

- Reset values: SlowReq=0, SlowHold=0, ClockGate=0, state=IDLE, Cnt=0, TL=0, GateL=0, prescaler=0, BACTr=0.
- Hit latency: BACT rises at edge N, so BACTr is still 0 through edge N+1. The FSM transitions at edge N+1, and SlowReq and ClockGate are high after edge N+1.
- All outputs are registered-state decodes; there is no combinational path from the inputs.
- TL=0: BACT falls at edge M, and SlowReq is low after edge M+1.
- TL=T>0: HOLD lasts T ticks, which is between (T-1)·TICK_DIV+1 and T·TICK_DIV CLK cycles depending on prescaler phase. SlowReq falls on the edge after the T-th tick.
- Back-to-back: BACT falls and rises within one cycle gap. HOLD is entered for one cycle and a hit reloads, so SlowReq stays continuously high with no glitch.

## Structure

- Shared package holds:
  - state encoding IDLE/ACTIVE/HOLD
  - the 4-bit timeout width constant
  - the default TICK_DIV
- Natural sub-module: slow_tick, the parameterised prescaler producing a one-cycle Tick.
- Hit-detection OR and FSM stay in the top module.

## Test plan

- **Reset:** assert nPOR=0 mid-HOLD (async, between edges) → all outputs 0 immediately. After release, prescaler restarts and first Tick occurs after TICK_DIV cycles.
- **Enabled hit, zero hold:** VIACS=1, SlowVIA=1, SlowTimeout=0, 4-cycle BACT → SlowReq high for cycles 2..5 relative to BACT rise, SlowHold never 1.
- **Disabled select:** SCSICS=1, SlowSCSI=0 → SlowReq stays 0. The same cycle with SlowSCSI=1 asserts it.
- **Hold length:** TICK_DIV=16, SlowTimeout=3, IWM hit → SlowHold high for between 33 and 48 cycles after BACT falls, then SlowReq=0.
- **Reload during hold:** SlowTimeout=2, a second SCC hit arrives on the same cycle as the final tick → ACTIVE re-entered, SlowReq never drops. The new TL equals the SlowTimeout value at the second hit (e.g. 5).
- **Gate latch:** SlowClockGate=1 at hit, then written to 0 during ACTIVE → ClockGate stays 1 until the window ends. The next window's ClockGate is 0.
